// File: rtl/sys_ctrl_cmd.sv
// Byte-command controller: 0xAA addr data writes, 0xBB addr reads back one byte over the TX load port.
// Define SYS_CTRL_WR_ACK_EN to answer every completed write with ack byte 0x55.
module sys_ctrl_cmd #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] REG0_RST   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_ERR,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] CFG_REG0,
    output logic                  CMD_ERR
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);
`ifdef SYS_CTRL_WR_ACK_EN
    localparam logic [DATA_WIDTH-1:0] WR_ACK = DATA_WIDTH'(8'h55);
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        SEND,
        TX_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_cmd_err;

    logic                    w_err;
    logic                    w_wr_en;
    logic                    w_addr_ld;
    logic                    w_tx_ld;
    logic                    w_tx_vld;
    logic [DATA_WIDTH-1:0]   w_tx_byte;
    logic [ADDR_WIDTH-1:0]   w_rx_addr;
    logic                    w_addr_bad;

    assign w_rx_addr  = RX_P_DATA[ADDR_WIDTH-1:0];
    // Any set bit above the address field makes the address byte invalid.
    assign w_addr_bad = |(RX_P_DATA >> ADDR_WIDTH);

    always_comb begin
        w_next    = r_state;
        w_err     = 1'b0;
        w_wr_en   = 1'b0;
        w_addr_ld = 1'b0;
        w_tx_ld   = 1'b0;
        w_tx_vld  = 1'b0;
        w_tx_byte = r_tx_data;
        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_ERR) begin
                        w_err = 1'b1;
                    end else if (RX_P_DATA == OP_WR) begin
                        w_next = WR_ADDR;
                    end else if (RX_P_DATA == OP_RD) begin
                        w_next = RD_ADDR;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (RX_ERR || w_addr_bad) begin
                        w_err  = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_addr_ld = 1'b1;
                        w_next    = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    if (RX_ERR) begin
                        w_err  = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_wr_en = 1'b1;
`ifdef SYS_CTRL_WR_ACK_EN
                        w_tx_ld   = 1'b1;
                        w_tx_byte = WR_ACK;
                        w_next    = SEND;
`else
                        w_next    = IDLE;
`endif
                    end
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (RX_ERR || w_addr_bad) begin
                        w_err  = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_tx_ld   = 1'b1;
                        w_tx_byte = r_mem[w_rx_addr];
                        w_next    = SEND;
                    end
                end
            end
            // Load strobe is combinational on TX_BUSY so it fires in the first idle cycle.
            SEND: begin
                if (!TX_BUSY) begin
                    w_tx_vld = 1'b1;
                    w_next   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (TX_BUSY) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_tx_data <= '0;
            r_cmd_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= (i == 0) ? REG0_RST : '0;
            end
        end else begin
            r_state   <= w_next;
            r_cmd_err <= w_err;
            if (w_addr_ld) begin
                r_addr <= w_rx_addr;
            end
            if (w_wr_en) begin
                r_mem[r_addr] <= RX_P_DATA;
            end
            if (w_tx_ld) begin
                r_tx_data <= w_tx_byte;
            end
        end
    end

    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = w_tx_vld;
    assign CFG_REG0  = r_mem[0];
    assign CMD_ERR   = r_cmd_err;
endmodule
